count_sequence_monitor: RTL and testbench
=========================================

COUNT_SEQUENCE_MONITOR -- requirements
Module: count_sequence_monitor

Interface
REQ-001 The block SHALL have parameter LOCK_LEN, default 4: consecutive correct increments required to reach LOCKED (legal range 1..15).
REQ-002 The block SHALL have parameter WRAP_W, default 8: width of wrap_cnt.
REQ-003 The block SHALL have parameter ERR_W, default 8: width of err_cnt.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port count_in, input, 2 bits: sample from the upstream 2-bit modulo-4 counter.
REQ-007 The block SHALL have port count_valid, input, 1 bit: count_in is sampled only when this is high.
REQ-008 The block SHALL have port clear_err, input, 1 bit: clears err_cnt and releases a sticky ERROR (see REQ-027).
REQ-009 The block SHALL have port locked, output, 1 bit: high while in the LOCKED state.
REQ-010 The block SHALL have port seq_err, output, 1 bit: one-cycle pulse when a sequence violation is detected in LOCKED.
REQ-011 The block SHALL have port wrap_pulse, output, 1 bit: one-cycle pulse when a 3->0 wrap is observed in LOCKED.
REQ-012 The block SHALL have port wrap_cnt, output, WRAP_W bits: saturating count of wraps.
REQ-013 The block SHALL have port err_cnt, output, ERR_W bits: saturating count of violations.
REQ-014 The block SHALL have port mon_state, output, 2 bits: encoded FSM state (IDLE=00, SYNC=01, LOCKED=10, ERROR=11).

Function
REQ-015 All outputs SHALL be registered; the response to a sample SHALL appear on the clock edge that captures it, i.e. visible in the following cycle.
REQ-016 A sample SHALL be "correct" when count_in == (prev + 1) mod 4, where prev is the last valid sample; prev SHALL update on every valid sample in every state.
REQ-017 Cycles with count_valid low SHALL hold state, prev, run length and counters, and SHALL produce no pulses.
REQ-018 IDLE: the first valid sample SHALL load prev, clear the run length and move the FSM to SYNC.
REQ-019 SYNC, correct sample: the run length SHALL increment; when it reaches LOCK_LEN the FSM SHALL move to LOCKED.
REQ-020 SYNC, incorrect sample: the run length SHALL reset to 0, with no seq_err and no err_cnt change.
REQ-021 LOCKED, correct sample: the FSM SHALL remain in LOCKED; if prev==3 and count_in==0, wrap_pulse SHALL assert and wrap_cnt SHALL increment, saturating at all-ones.
REQ-022 LOCKED, incorrect sample: seq_err SHALL assert, err_cnt SHALL increment (saturating), the FSM SHALL move to ERROR, and locked SHALL drop.
REQ-023 Wraps observed outside LOCKED SHALL NOT be counted or pulsed.
REQ-024 When clear_err and an error increment occur in the same cycle, err_cnt SHALL become 1.
REQ-025 When clear_err is asserted with no error increment, err_cnt SHALL become 0 in any state.

Reset
REQ-026 While rst is low, the block SHALL immediately hold state=IDLE, prev=0, run length=0, locked=0, seq_err=0, wrap_pulse=0, wrap_cnt=0 and err_cnt=0, including when rst falls mid-LOCKED or mid-ERROR; after rst rises, the first valid sample SHALL follow REQ-018.

Configuration
REQ-027 With macro SEQ_MON_STICKY_ERR_EN defined, ERROR SHALL persist until a cycle with clear_err high, then move to SYNC with run length 0; samples in ERROR SHALL update only prev.
REQ-028 Without SEQ_MON_STICKY_ERR_EN, ERROR SHALL last exactly one cycle and then move to SYNC with run length 0, regardless of count_valid or clear_err.

Verification
REQ-029 Reset, then valid samples 0,1,2,3,0 -> mon_state shall step IDLE->SYNC and show LOCKED after the 5th sample, with locked=1, wrap_pulse=0 and wrap_cnt=0.
REQ-030 From locked, samples 1,2,3,0 -> a single wrap_pulse shall occur one cycle after the 0 sample, and wrap_cnt=1.
REQ-031 From locked after a 0, sample 2 -> seq_err pulses for 1 cycle, err_cnt=1 and locked=0; without the macro, mon_state reads ERROR for 1 cycle then SYNC.
REQ-032 With SEQ_MON_STICKY_ERR_EN, after an error, samples 3,0,1 then clear_err -> mon_state stays ERROR until clear_err, then reads SYNC with err_cnt=0; error plus clear_err in the same cycle -> err_cnt=1.
REQ-033 With WRAP_W=2, 5 wraps in LOCKED -> wrap_cnt reads 3 and stays at 3, with wrap_pulse still asserted on every wrap.
REQ-034 Locked with count_valid low for 10 cycles, then sample prev+1 -> no change and no pulses during the gap, and locked stays 1; rst low mid-LOCKED asynchronously zeroes all outputs.

Source files
------------

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
// Watches a free-running 2-bit modulo-4 counter and checks that every valid
// sample is the previous valid sample plus one. Once LOCK_LEN consecutive
// correct increments are seen the monitor is LOCKED. While locked it pulses
// on 3->0 wraps, flags violations, and keeps saturating wrap and error counts.
//
// Build option: define SEQ_MON_STICKY_ERR_EN to make ERROR persist until a
// cycle with clear_err high. Without it, ERROR lasts exactly one cycle and
// then the monitor falls back to SYNC on its own.
//
// All outputs come straight from registers. The response to a sample is
// visible in the cycle after the edge that captures it.

module count_sequence_monitor #(
    parameter int LOCK_LEN = 4,   // correct increments needed to lock (1..15)
    parameter int WRAP_W   = 8,   // width of wrap_cnt
    parameter int ERR_W    = 8    // width of err_cnt
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic [1:0]        count_in,
    input  logic              count_valid,
    input  logic              clear_err,
    output logic              locked,
    output logic              seq_err,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        mon_state
);

    // State encoding is visible on mon_state, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_LOCKED = 2'b10,
        ST_ERROR  = 2'b11
    } state_t;

    // The run length never needs to exceed 15, because LOCK_LEN is at most 15.
    localparam logic [3:0]        LOCK_LEN_C = 4'(LOCK_LEN);
    localparam logic [WRAP_W-1:0] WRAP_MAX   = {WRAP_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ONE   = WRAP_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE    = ERR_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        prev_q, prev_d;
    logic [3:0]        run_q, run_d;
    logic              locked_q, locked_d;
    logic              seq_err_q, seq_err_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic              sample_ok;
    logic              wrap_seen;
    logic              err_inc;
    logic              wrap_inc;

    // Decode the current sample against the previously accepted one.
    always_comb begin
        sample_ok = (count_in == 2'(prev_q + 2'd1));
        wrap_seen = (prev_q == 2'd3) && (count_in == 2'd0);
    end

    // Next-state logic: FSM transitions, prev tracking, run length and pulses.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        seq_err_d    = 1'b0;
        wrap_pulse_d = 1'b0;
        err_inc      = 1'b0;
        wrap_inc     = 1'b0;

        // prev follows every valid sample, in every state.
        if (count_valid) begin
            prev_d = count_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_valid) begin
                    state_d = ST_SYNC;
                    run_d   = 4'd0;
                end
            end

            ST_SYNC: begin
                if (count_valid) begin
                    if (sample_ok) begin
                        if (4'(run_q + 4'd1) == LOCK_LEN_C) begin
                            state_d = ST_LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = 4'(run_q + 4'd1);
                        end
                    end else begin
                        // Losing sync before lock is not an error; restart the run.
                        run_d = 4'd0;
                    end
                end
            end

            ST_LOCKED: begin
                if (count_valid) begin
                    if (sample_ok) begin
                        if (wrap_seen) begin
                            wrap_pulse_d = 1'b1;
                            wrap_inc     = 1'b1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        err_inc   = 1'b1;
                        state_d   = ST_ERROR;
                        run_d     = 4'd0;
                    end
                end
            end

            ST_ERROR: begin
`ifdef SEQ_MON_STICKY_ERR_EN
                // Stay here until software acknowledges; samples only move prev.
                if (clear_err) begin
                    state_d = ST_SYNC;
                    run_d   = 4'd0;
                end
`else
                // One-cycle error indication, then try to resynchronise.
                state_d = ST_SYNC;
                run_d   = 4'd0;
`endif
            end

            default: begin
                state_d = ST_IDLE;
                run_d   = 4'd0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    // Saturating wrap counter.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_inc && (wrap_cnt_q != WRAP_MAX)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
        end
    end

    // Saturating error counter. An error in the same cycle as clear_err
    // counts as the first error after the clear.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc) begin
            if (clear_err) begin
                err_cnt_d = ERR_ONE;
            end else if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
        end else if (clear_err) begin
            err_cnt_d = '0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= 2'd0;
            run_q        <= 4'd0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            locked_q     <= locked_d;
            seq_err_q    <= seq_err_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Drive the output ports from the registers.
    always_comb begin
        locked     = locked_q;
        seq_err    = seq_err_q;
        wrap_pulse = wrap_pulse_q;
        wrap_cnt   = wrap_cnt_q;
        err_cnt    = err_cnt_q;
        mon_state  = state_q;
    end

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Scoreboard bench for count_sequence_monitor.
// Two instances share the same stimulus: the default one, and one built
// with WRAP_W=2 so that wrap-count saturation is observable.

module tb_count_sequence_monitor;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_S = 2'd1;
    localparam logic [1:0] S_L = 2'd2;
    localparam logic [1:0] S_E = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] count_in = 2'd0;
    logic       count_valid = 1'b0;
    logic       clear_err = 1'b0;

    logic       locked, seq_err, wrap_pulse;
    logic [7:0] wrap_cnt, err_cnt;
    logic [1:0] mon_state;

    logic       locked2, seq_err2, wrap_pulse2;
    logic [1:0] wrap_cnt2;
    logic [7:0] err_cnt2;
    logic [1:0] mon_state2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       lk;
        logic       se;
        logic       wp;
        logic [7:0] wc;
        logic [1:0] wc2;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];

    count_sequence_monitor #(.LOCK_LEN(4), .WRAP_W(8), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .clear_err(clear_err), .locked(locked), .seq_err(seq_err),
        .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt),
        .mon_state(mon_state)
    );

    count_sequence_monitor #(.LOCK_LEN(4), .WRAP_W(2), .ERR_W(8)) u_dut_w2 (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .clear_err(clear_err), .locked(locked2), .seq_err(seq_err2),
        .wrap_pulse(wrap_pulse2), .wrap_cnt(wrap_cnt2), .err_cnt(err_cnt2),
        .mon_state(mon_state2)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".state"},     int'(mon_state),   0);
        check({tag, ".locked"},    int'(locked),      0);
        check({tag, ".seq_err"},   int'(seq_err),     0);
        check({tag, ".wrap"},      int'(wrap_pulse),  0);
        check({tag, ".wrap_cnt"},  int'(wrap_cnt),    0);
        check({tag, ".err_cnt"},   int'(err_cnt),     0);
        check({tag, ".wrap_cnt2"}, int'(wrap_cnt2),   0);
        check({tag, ".state2"},    int'(mon_state2),  0);
        $display("reset %s: state=%0d locked=%0b wrap_cnt=%0d err_cnt=%0d",
                 tag, mon_state, locked, wrap_cnt, err_cnt);
    endtask

    // Drive one cycle of stimulus and queue the hand-computed response.
    task automatic step(input logic v, input logic [1:0] c, input logic clr,
                        input logic [1:0] st, input logic se, input logic wp,
                        input int wc, input int w2, input int ec, input string nm);
        exp_t e;
        @(negedge clk);
        count_valid = v;
        count_in    = c;
        clear_err   = clr;
        e.name = nm;
        e.st   = st;
        e.lk   = (st == S_L);
        e.se   = se;
        e.wp   = wp;
        e.wc   = 8'(wc);
        e.wc2  = 2'(w2);
        e.ec   = 8'(ec);
        exp_q.push_back(e);
    endtask

    // Monitor: after each capturing edge, compare against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".state"},     int'(mon_state),   int'(e.st));
                check({e.name, ".locked"},    int'(locked),      int'(e.lk));
                check({e.name, ".seq_err"},   int'(seq_err),     int'(e.se));
                check({e.name, ".wrap"},      int'(wrap_pulse),  int'(e.wp));
                check({e.name, ".wrap_cnt"},  int'(wrap_cnt),    int'(e.wc));
                check({e.name, ".err_cnt"},   int'(err_cnt),     int'(e.ec));
                check({e.name, ".wrap_cnt2"}, int'(wrap_cnt2),   int'(e.wc2));
                check({e.name, ".wrap2"},     int'(wrap_pulse2), int'(e.wp));
                check({e.name, ".state2"},    int'(mon_state2),  int'(e.st));
                $display("txn %s: state=%0d locked=%0b seq_err=%0b wrap=%0b wrap_cnt=%0d wrap_cnt2=%0d err_cnt=%0d",
                         e.name, mon_state, locked, seq_err, wrap_pulse,
                         wrap_cnt, wrap_cnt2, err_cnt);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int guard;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("por");
        rst = 1'b1;

        // Acquire lock: 0,1,2,3,0 (the 3->0 in SYNC is not a counted wrap).
        step(1, 2'd0, 0, S_S, 0, 0, 0, 0, 0, "lock_s0");
        step(1, 2'd1, 0, S_S, 0, 0, 0, 0, 0, "lock_s1");
        step(1, 2'd2, 0, S_S, 0, 0, 0, 0, 0, "lock_s2");
        step(1, 2'd3, 0, S_S, 0, 0, 0, 0, 0, "lock_s3");
        step(1, 2'd0, 0, S_L, 0, 0, 0, 0, 0, "lock_s4");

        // One full lap in LOCKED: single wrap on the 0 sample.
        step(1, 2'd1, 0, S_L, 0, 0, 0, 0, 0, "lap1_1");
        step(1, 2'd2, 0, S_L, 0, 0, 0, 0, 0, "lap1_2");
        step(1, 2'd3, 0, S_L, 0, 0, 0, 0, 0, "lap1_3");
        step(1, 2'd0, 0, S_L, 0, 1, 1, 1, 0, "lap1_wrap");

        // Gap with count_valid low and a wrong value on count_in.
        for (int i = 0; i < 10; i++) begin
            step(0, 2'd2, 0, S_L, 0, 0, 1, 1, 0, $sformatf("gap%0d", i));
        end
        step(1, 2'd1, 0, S_L, 0, 0, 1, 1, 0, "after_gap");

        // Four more wraps: the 2-bit instance saturates at 3.
        step(1, 2'd2, 0, S_L, 0, 0, 1, 1, 0, "lap2_2");
        step(1, 2'd3, 0, S_L, 0, 0, 1, 1, 0, "lap2_3");
        step(1, 2'd0, 0, S_L, 0, 1, 2, 2, 0, "lap2_wrap");
        step(1, 2'd1, 0, S_L, 0, 0, 2, 2, 0, "lap3_1");
        step(1, 2'd2, 0, S_L, 0, 0, 2, 2, 0, "lap3_2");
        step(1, 2'd3, 0, S_L, 0, 0, 2, 2, 0, "lap3_3");
        step(1, 2'd0, 0, S_L, 0, 1, 3, 3, 0, "lap3_wrap");
        step(1, 2'd1, 0, S_L, 0, 0, 3, 3, 0, "lap4_1");
        step(1, 2'd2, 0, S_L, 0, 0, 3, 3, 0, "lap4_2");
        step(1, 2'd3, 0, S_L, 0, 0, 3, 3, 0, "lap4_3");
        step(1, 2'd0, 0, S_L, 0, 1, 4, 3, 0, "lap4_wrap");
        step(1, 2'd1, 0, S_L, 0, 0, 4, 3, 0, "lap5_1");
        step(1, 2'd2, 0, S_L, 0, 0, 4, 3, 0, "lap5_2");
        step(1, 2'd3, 0, S_L, 0, 0, 4, 3, 0, "lap5_3");
        step(1, 2'd0, 0, S_L, 0, 1, 5, 3, 0, "lap5_wrap");

        // Violation after a 0: sample 2.
        step(1, 2'd2, 0, S_E, 1, 0, 5, 3, 1, "viol");

`ifdef SEQ_MON_STICKY_ERR_EN
        step(1, 2'd3, 0, S_E, 0, 0, 5, 3, 1, "sticky_3");
        step(1, 2'd0, 0, S_E, 0, 0, 5, 3, 1, "sticky_0");
        step(1, 2'd1, 0, S_E, 0, 0, 5, 3, 1, "sticky_1");
        step(0, 2'd0, 1, S_S, 0, 0, 5, 3, 0, "sticky_clr");
        step(1, 2'd2, 0, S_S, 0, 0, 5, 3, 0, "resync_1");
        step(1, 2'd3, 0, S_S, 0, 0, 5, 3, 0, "resync_2");
        step(1, 2'd0, 0, S_S, 0, 0, 5, 3, 0, "resync_3");
        step(1, 2'd1, 0, S_L, 0, 0, 5, 3, 0, "resync_lock");
        step(1, 2'd3, 1, S_E, 1, 0, 5, 3, 1, "err_with_clr");
        step(0, 2'd0, 0, S_E, 0, 0, 5, 3, 1, "sticky_hold");
`else
        step(0, 2'd0, 0, S_S, 0, 0, 5, 3, 1, "err_to_sync");
        step(1, 2'd3, 0, S_S, 0, 0, 5, 3, 1, "resync_1");
        step(1, 2'd0, 0, S_S, 0, 0, 5, 3, 1, "resync_2");
        step(1, 2'd1, 0, S_S, 0, 0, 5, 3, 1, "resync_3");
        step(1, 2'd2, 0, S_L, 0, 0, 5, 3, 1, "resync_lock");
        step(0, 2'd0, 1, S_L, 0, 0, 5, 3, 0, "clr_only");
        step(1, 2'd0, 1, S_E, 1, 0, 5, 3, 1, "err_with_clr");
        // Sample taken during ERROR must become prev.
        step(1, 2'd3, 0, S_S, 0, 0, 5, 3, 1, "err_sample");
        step(1, 2'd0, 0, S_S, 0, 0, 5, 3, 1, "prev_from_err");
        step(1, 2'd1, 0, S_S, 0, 0, 5, 3, 1, "relock_2");
        step(1, 2'd2, 0, S_S, 0, 0, 5, 3, 1, "relock_3");
        step(1, 2'd3, 0, S_L, 0, 0, 5, 3, 1, "relock_4");
        step(1, 2'd0, 0, S_L, 0, 1, 6, 3, 1, "relock_wrap");
        step(0, 2'd0, 0, S_L, 0, 0, 6, 3, 1, "idle_locked");
`endif

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async");
        repeat (2) @(posedge clk);
        #1 check_zero("held");
        @(negedge clk);
        rst = 1'b1;

        // After reset the first sample follows the IDLE rule; an incorrect
        // sample in SYNC restarts the run.
        step(1, 2'd2, 0, S_S, 0, 0, 0, 0, 0, "post_rst_0");
        step(1, 2'd3, 0, S_S, 0, 0, 0, 0, 0, "post_rst_1");
        step(1, 2'd1, 0, S_S, 0, 0, 0, 0, 0, "sync_bad");
        step(1, 2'd2, 0, S_S, 0, 0, 0, 0, 0, "sync_r1");
        step(1, 2'd3, 0, S_S, 0, 0, 0, 0, 0, "sync_r2");
        step(1, 2'd0, 0, S_S, 0, 0, 0, 0, 0, "sync_r3");
        step(1, 2'd1, 0, S_L, 0, 0, 0, 0, 0, "sync_r4");
        step(0, 2'd1, 0, S_L, 0, 0, 0, 0, 0, "final_idle");

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
